// File: rtl/rename_ckpt.sv
// Register rename stage with a circular free list, per-branch map checkpoints and committed-map recovery.
// Optional RENAME_CKPT_STALL_CNT_EN adds a saturating stall_cnt output counting lane-0 stall cycles.
module rename_ckpt #(
    parameter int RWD   = 2,
    parameter int CWD   = 2,
    parameter int PRNUM = 64,
    parameter int BRSZ  = 4,
    localparam int PW   = $clog2(PRNUM),
    localparam int FD   = PRNUM - 32,
    localparam int FW   = $clog2(FD),
    localparam int BW   = (BRSZ > 1) ? $clog2(BRSZ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RWD-1:0]           in_valid,
    input  logic [RWD-1:0][4:0]      in_rd,
    input  logic [RWD-1:0][4:0]      in_rs1,
    input  logic [RWD-1:0][4:0]      in_rs2,
    input  logic [RWD-1:0]           in_br,
    input  logic [RWD-1:0][BW-1:0]   in_brid,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RWD-1:0][PW-1:0]   out_prs1,
    output logic [RWD-1:0][PW-1:0]   out_prs2,
    output logic [RWD-1:0][PW-1:0]   out_prd,
    output logic [RWD-1:0][PW-1:0]   out_prd_old,
    output logic [RWD-1:0]           out_lane,
    input  logic [CWD-1:0]           com_valid,
    input  logic [CWD-1:0][4:0]      com_rd,
    input  logic [CWD-1:0][PW-1:0]   com_prd,
    input  logic [CWD-1:0][PW-1:0]   com_prd_old,
    input  logic                     redir,
    input  logic                     redir_ckpt,
    input  logic [BW-1:0]            redir_brid,
    output logic [FW:0]              free_cnt
`ifdef RENAME_CKPT_STALL_CNT_EN
   ,output logic [31:0]              stall_cnt
`endif
);

    logic [PW-1:0] r_map     [32];
    logic [PW-1:0] r_cmap    [32];
    logic [PW-1:0] r_fl      [FD];
    logic [PW-1:0] r_ck_map  [BRSZ][32];
    logic [FW:0]   r_ck_head [BRSZ];
    logic [FW:0]   r_head, r_tail;

    logic                   r_out_valid;
    logic [RWD-1:0]         r_out_lane;
    logic [RWD-1:0][PW-1:0] r_prs1, r_prs2, r_prd, r_prd_old;

    logic [PW-1:0]          w_map    [32];
    logic [PW-1:0]          w_ck_map [RWD][32];
    logic [FW:0]            w_ck_head [RWD];
    logic [FW:0]            w_head, w_nalloc;
    logic [RWD-1:0][PW-1:0] w_prs1, w_prs2, w_prd, w_prd_old;

    logic [FW:0]            w_tail;
    logic [PW-1:0]          w_cmap [32];
    logic [CWD-1:0]         w_push;
    logic [CWD-1:0][FW-1:0] w_slot;
    logic                   w_accept;

    // Walk the lanes in order so later lanes see earlier destination writes
    always_comb begin
        w_map     = r_map;
        w_head    = r_head;
        w_nalloc  = '0;
        w_prs1    = '0;
        w_prs2    = '0;
        w_prd     = '0;
        w_prd_old = '0;
        for (int i = 0; i < RWD; i++) begin
            w_ck_map[i]  = r_map;
            w_ck_head[i] = r_head;
        end
        for (int i = 0; i < RWD; i++) begin
            if (in_valid[i]) begin
                w_prs1[i] = (in_rs1[i] == 5'd0) ? '0 : w_map[in_rs1[i]];
                w_prs2[i] = (in_rs2[i] == 5'd0) ? '0 : w_map[in_rs2[i]];
                if (in_rd[i] != 5'd0) begin
                    w_prd[i]          = r_fl[w_head[FW-1:0]];
                    w_prd_old[i]      = w_map[in_rd[i]];
                    w_map[in_rd[i]]   = r_fl[w_head[FW-1:0]];
                    w_head            = w_head + 1'b1;
                    w_nalloc          = w_nalloc + 1'b1;
                end
                w_ck_map[i]  = w_map;
                w_ck_head[i] = w_head;
            end
        end
    end

    always_comb begin
        w_tail = r_tail;
        w_cmap = r_cmap;
        w_push = '0;
        w_slot = '0;
        for (int c = 0; c < CWD; c++) begin
            if (com_valid[c]) begin
                if (com_prd_old[c] != '0) begin
                    w_push[c] = 1'b1;
                    w_slot[c] = w_tail[FW-1:0];
                    w_tail    = w_tail + 1'b1;
                end
                if (com_rd[c] != 5'd0)
                    w_cmap[com_rd[c]] = com_prd[c];
            end
        end
    end

    assign free_cnt  = r_tail - r_head;
    assign in_ready  = !redir && (free_cnt >= w_nalloc) && (!r_out_valid || out_ready);
    assign w_accept  = in_ready && in_valid[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_map[i]  <= PW'(i);
                r_cmap[i] <= PW'(i);
            end
            for (int i = 0; i < FD; i++)
                r_fl[i] <= PW'(32 + i);
            r_head      <= '0;
            r_tail      <= (FW+1)'(FD);
            r_out_valid <= 1'b0;
            r_out_lane  <= '0;
            r_prs1      <= '0;
            r_prs2      <= '0;
            r_prd       <= '0;
            r_prd_old   <= '0;
        end else begin
            r_tail <= w_tail;
            r_cmap <= w_cmap;
            for (int c = 0; c < CWD; c++)
                if (w_push[c])
                    r_fl[w_slot[c]] <= com_prd_old[c];
            if (redir) begin
                r_out_valid <= 1'b0;
                if (redir_ckpt) begin
                    r_map  <= r_ck_map[redir_brid];
                    r_head <= r_ck_head[redir_brid];
                end else begin
                    // Everything not committed returns: the list becomes full behind the new tail
                    r_map  <= w_cmap;
                    r_head <= w_tail - (FW+1)'(FD);
                end
            end else if (w_accept) begin
                r_map       <= w_map;
                r_head      <= w_head;
                r_out_valid <= 1'b1;
                r_out_lane  <= in_valid;
                r_prs1      <= w_prs1;
                r_prs2      <= w_prs2;
                r_prd       <= w_prd;
                r_prd_old   <= w_prd_old;
                for (int i = 0; i < RWD; i++) begin
                    if (in_valid[i] && in_br[i]) begin
                        r_ck_map[in_brid[i]]  <= w_ck_map[i];
                        r_ck_head[in_brid[i]] <= w_ck_head[i];
                    end
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_lane    = r_out_lane;
    assign out_prs1    = r_prs1;
    assign out_prs2    = r_prs2;
    assign out_prd     = r_prd;
    assign out_prd_old = r_prd_old;

`ifdef RENAME_CKPT_STALL_CNT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if (in_valid[0] && !in_ready && (r_stall != '1))
            r_stall <= r_stall + 1'b1;
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_rename_ckpt.sv
// Directed bench for rename_ckpt: reference map/free-list model plus an output scoreboard queue.
module tb_rename_ckpt;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           in_valid, in_br;
    logic [1:0][4:0]      in_rd, in_rs1, in_rs2;
    logic [1:0][1:0]      in_brid;
    logic                 in_ready, out_valid, out_ready;
    logic [1:0][5:0]      out_prs1, out_prs2, out_prd, out_prd_old;
    logic [1:0]           out_lane;
    logic [1:0]           com_valid;
    logic [1:0][4:0]      com_rd;
    logic [1:0][5:0]      com_prd, com_prd_old;
    logic                 redir, redir_ckpt;
    logic [1:0]           redir_brid;
    logic [5:0]           free_cnt;
`ifdef RENAME_CKPT_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    rename_ckpt dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_br(in_br), .in_brid(in_brid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_prd_old(out_prd_old), .out_lane(out_lane),
        .com_valid(com_valid), .com_rd(com_rd), .com_prd(com_prd), .com_prd_old(com_prd_old),
        .redir(redir), .redir_ckpt(redir_ckpt), .redir_brid(redir_brid),
        .free_cnt(free_cnt)
`ifdef RENAME_CKPT_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      lane;
        logic [1:0][5:0] prs1, prs2, prd, old;
    } exp_t;

    exp_t        sb[$];
    int          m_map[32], m_cmap[32], m_fl[32], ck_map[4][32], ck_head[4];
    int          m_head, m_tail;
    bit          m_ov, m_known;
    logic [31:0] m_stall;
    int          errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i; m_cmap[i] = i; m_fl[i] = 32 + i;
        end
        m_head = 0; m_tail = 32; m_ov = 0; m_stall = '0; m_known = 1;
        sb.delete();
    endtask

    // One clock: compare DUT against the model, advance the model, then step the clock
    task automatic cyc();
        bit   exp_rdy, acc;
        int   nalloc;
        int   tmap[32];
        exp_t e;
        acc = 0;
        #1;
        nalloc = 0;
        for (int l = 0; l < 2; l++)
            if (in_valid[l] && in_rd[l] != 5'd0) nalloc++;
        exp_rdy = !redir && ((m_tail - m_head) >= nalloc) && (!m_ov || out_ready);
        if (rst) begin
            model_reset();
        end else if (m_known) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov && sb.size() > 0) begin
                e = sb[0];
                chk("out_lane", 32'(out_lane), 32'(e.lane));
                for (int l = 0; l < 2; l++) begin
                    chk("out_prs1", 32'(out_prs1[l]), 32'(e.prs1[l]));
                    chk("out_prs2", 32'(out_prs2[l]), 32'(e.prs2[l]));
                    chk("out_prd", 32'(out_prd[l]), 32'(e.prd[l]));
                    chk("out_prd_old", 32'(out_prd_old[l]), 32'(e.old[l]));
                end
                if (out_ready) e = sb.pop_front();
            end
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("free_cnt", 32'(free_cnt), m_tail - m_head);
`ifdef RENAME_CKPT_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
            acc = exp_rdy && in_valid[0];
            if (in_valid[0] && !exp_rdy && m_stall != 32'hffffffff) m_stall = m_stall + 1;
            if (acc) begin
                tmap = m_map;
                e = '0;
                for (int l = 0; l < 2; l++) begin
                    if (in_valid[l]) begin
                        e.lane[l] = 1'b1;
                        e.prs1[l] = (in_rs1[l] == 5'd0) ? 6'd0 : 6'(tmap[in_rs1[l]]);
                        e.prs2[l] = (in_rs2[l] == 5'd0) ? 6'd0 : 6'(tmap[in_rs2[l]]);
                        if (in_rd[l] != 5'd0) begin
                            e.prd[l] = 6'(m_fl[m_head % 32]);
                            e.old[l] = 6'(tmap[in_rd[l]]);
                            tmap[in_rd[l]] = m_fl[m_head % 32];
                            m_head++;
                        end
                        if (in_br[l]) begin
                            ck_map[in_brid[l]]  = tmap;
                            ck_head[in_brid[l]] = m_head;
                        end
                    end
                end
                m_map = tmap;
                sb.push_back(e);
                m_ov = 1;
            end else if (redir || out_ready) begin
                m_ov = 0;
            end
            for (int c = 0; c < 2; c++) begin
                if (com_valid[c]) begin
                    if (com_prd_old[c] != 6'd0) begin
                        m_fl[m_tail % 32] = int'(com_prd_old[c]);
                        m_tail++;
                    end
                    if (com_rd[c] != 5'd0) m_cmap[com_rd[c]] = int'(com_prd[c]);
                end
            end
            if (redir) begin
                if (redir_ckpt) begin
                    m_map  = ck_map[redir_brid];
                    m_head = ck_head[redir_brid];
                end else begin
                    m_map  = m_cmap;
                    m_head = m_tail - 32;
                end
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin in_valid = '0; in_br = '0; end
        com_valid = '0; redir = 0; redir_ckpt = 0;
    endtask

    task automatic grp(input logic [1:0] v, input logic [4:0] rd0, rs10, rs20,
                       input logic [4:0] rd1, rs11, rs21);
        in_valid = v; in_br = '0; in_brid = '0;
        in_rd[0] = rd0; in_rs1[0] = rs10; in_rs2[0] = rs20;
        in_rd[1] = rd1; in_rs1[1] = rs11; in_rs2[1] = rs21;
    endtask

    task automatic go();
        int k;
        k = 0;
        while (in_valid != 2'b00 && k < 20) begin cyc(); k++; end
        if (in_valid != 2'b00) begin
            chk("accept_timeout", 32'(in_valid), 32'd0);
            in_valid = '0;
        end
    endtask

    int pre1, pre2, c1, c2, bx1, bx2;

    initial begin
        rst = 1; in_valid = '0; in_br = '0; in_brid = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        out_ready = 1; com_valid = '0; com_rd = '0; com_prd = '0; com_prd_old = '0;
        redir = 0; redir_ckpt = 0; redir_brid = '0; m_known = 0;
        cyc(); cyc();
        rst = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_lane", 32'(out_lane), 32'd0);
        chk("rst_out_prd", 32'(out_prd), 32'd0);
        chk("rst_free_cnt", 32'(free_cnt), 32'd32);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic group with intra-group dependency
        grp(2'b11, 5'd1, 5'd0, 5'd0, 5'd2, 5'd1, 5'd0);
        go();
        chk("g1_prd0", 32'(out_prd[0]), 32'd32);
        chk("g1_prd1", 32'(out_prd[1]), 32'd33);
        chk("g1_prs1_1", 32'(out_prs1[1]), 32'd32);
        chk("g1_old0", 32'(out_prd_old[0]), 32'd1);
        chk("g1_old1", 32'(out_prd_old[1]), 32'd2);
        chk("g1_free", 32'(free_cnt), 32'd30);
        cyc();

        // Drain the free list, then free p5 and reallocate it
        for (int g = 0; g < 15; g++) begin
            grp(2'b11, 5'd3, 5'd1, 5'd2, 5'd4, 5'd3, 5'd0);
            go();
        end
        chk("drain_free", 32'(free_cnt), 32'd0);
        grp(2'b01, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("drain_ready0", 32'(in_ready), 32'd0);
        com_valid = 2'b01; com_rd[0] = 5'd3; com_prd[0] = 6'(m_map[3]); com_prd_old[0] = 6'd5;
        cyc();
        chk("freed_ready1", 32'(in_ready), 32'd1);
        go();
        chk("freed_p5", 32'(out_prd[0]), 32'd5);
        cyc();

        // Exception recovery to committed state
        redir = 1; redir_ckpt = 0;
        cyc();
        chk("exc0_free", 32'(free_cnt), 32'd32);
        pre1 = m_map[1]; pre2 = m_map[2];
        for (int g = 0; g < 5; g++) begin
            grp(2'b11, 5'd1, 5'd0, 5'd0, 5'd2, 5'd1, 5'd0);
            go();
            if (g == 0) begin c1 = m_map[1]; c2 = m_map[2]; end
        end
        com_valid = 2'b11;
        com_rd[0] = 5'd1; com_prd[0] = 6'(c1); com_prd_old[0] = 6'(pre1);
        com_rd[1] = 5'd2; com_prd[1] = 6'(c2); com_prd_old[1] = 6'(pre2);
        cyc();
        chk("exc_pre_free", 32'(free_cnt), 32'd24);
        redir = 1; redir_ckpt = 0;
        cyc();
        chk("exc_free", 32'(free_cnt), 32'd32);
        chk("exc_out_valid", 32'(out_valid), 32'd0);
        grp(2'b11, 5'd3, 5'd1, 5'd2, 5'd4, 5'd2, 5'd1);
        go();
        chk("exc_x1", 32'(out_prs1[0]), 32'(c1));
        chk("exc_x2", 32'(out_prs2[0]), 32'(c2));
        cyc();

        // Branch checkpoint then recovery from it
        bx2 = m_map[2];
        grp(2'b11, 5'd1, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0);
        in_br = 2'b01; in_brid[0] = 2'd1;
        go();
        bx1 = m_map[1];
        for (int g = 0; g < 3; g++) begin
            grp(2'b01, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0);
            go();
        end
        com_valid = 2'b01; com_rd[0] = 5'd0; com_prd[0] = 6'd0; com_prd_old[0] = 6'd7;
        cyc();
        redir = 1; redir_ckpt = 1; redir_brid = 2'd1;
        cyc();
        chk("ckpt_free", 32'(free_cnt), 32'd30);
        grp(2'b01, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0);
        go();
        chk("ckpt_x1", 32'(out_prs1[0]), 32'(bx1));
        chk("ckpt_x2", 32'(out_prs2[0]), 32'(bx2));
        cyc();

        // Output backpressure
        out_ready = 0;
        grp(2'b11, 5'd5, 5'd3, 5'd1, 5'd6, 5'd5, 5'd0);
        go();
        grp(2'b01, 5'd8, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_ready0", 32'(in_ready), 32'd0);
            cyc();
        end
        out_ready = 1;
        #1;
        chk("release_ready", 32'(in_ready), 32'd1);
        go();
        cyc();

`ifdef RENAME_CKPT_STALL_CNT_EN
        rst = 1; cyc(); rst = 0;
        out_ready = 0;
        grp(2'b01, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        go();
        grp(2'b01, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 5; k++) cyc();
        chk("stall5", stall_cnt, 32'd5);
        rst = 1; in_valid = '0; cyc(); rst = 0; out_ready = 1;
        chk("stall_rst", stall_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
